// File: rtl/sram_access_ctrl.sv
// Single-port SRAM access sequencer: precharge -> wordline (+write driver) -> sense -> done.
// Optional SRAM_WR_VERIFY_EN adds a readback-and-compare pass after every write.
module sram_access_ctrl #(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int ADDR_W  = 3,
  parameter int PRE_CYC = 2,
  parameter int WL_CYC  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [COLS-1:0]   wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [COLS-1:0]   rdata,
  output logic              pre_en,
  output logic [ROWS-1:0]   wl,
  output logic              wr_en,
  output logic [COLS-1:0]   wr_data,
  output logic              sae,
  input  logic [COLS-1:0]   sa_out
);

  localparam int MAXC  = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int CNT_W = $clog2(MAXC) + 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] WL_LAST  = CNT_W'(WL_CYC - 1);

  typedef enum logic [2:0] {IDLE, PRECH, ACCESS, SENSE, DONE} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy, r_done, r_err, r_pre_en, r_wr_en, r_sae;
  logic [ROWS-1:0]   r_wl;
  logic [COLS-1:0]   r_wr_data, r_rdata;
`ifdef SRAM_WR_VERIFY_EN
  logic              r_verify;
`endif

  logic              w_in_range;
  logic [ROWS-1:0]   w_wl_dec;
  logic              w_wr_phase;
  logic              w_mis;

  assign w_in_range = (32'(r_addr) < ROWS);

  always_comb begin
    w_wl_dec = '0;
    for (int i = 0; i < ROWS; i++) w_wl_dec[i] = (r_addr == ADDR_W'(i));
  end

`ifdef SRAM_WR_VERIFY_EN
  // Readback pass reuses PRECH/ACCESS with the write driver held off.
  assign w_wr_phase = r_we && !r_verify;
  assign w_mis      = r_verify && w_in_range && (sa_out != r_wr_data);
`else
  assign w_wr_phase = r_we;
  assign w_mis      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_pre_en  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_sae     <= 1'b0;
      r_wl      <= '0;
      r_wr_data <= '0;
      r_rdata   <= '0;
`ifdef SRAM_WR_VERIFY_EN
      r_verify  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (req) begin
          r_we     <= we;
          r_addr   <= addr;
          if (we) r_wr_data <= wdata;
          r_state  <= PRECH;
          r_cnt    <= '0;
          r_busy   <= 1'b1;
          r_pre_en <= 1'b1;
          r_err    <= 1'b0;
`ifdef SRAM_WR_VERIFY_EN
          r_verify <= 1'b0;
`endif
        end
        PRECH: if (r_cnt == PRE_LAST) begin
          r_cnt    <= '0;
          r_pre_en <= 1'b0;
          r_state  <= ACCESS;
          r_wl     <= w_in_range ? w_wl_dec : '0;
          r_wr_en  <= w_in_range && w_wr_phase;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        ACCESS: if (r_cnt == WL_LAST) begin
          r_cnt   <= '0;
          r_wl    <= '0;
          r_wr_en <= 1'b0;
          if (w_wr_phase) begin
`ifdef SRAM_WR_VERIFY_EN
            r_verify <= 1'b1;
            r_pre_en <= 1'b1;
            r_state  <= PRECH;
`else
            r_done  <= 1'b1;
            r_err   <= !w_in_range;
            r_state <= DONE;
`endif
          end else begin
            r_sae   <= w_in_range;
            r_state <= SENSE;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        SENSE: begin
          r_sae   <= 1'b0;
          if (w_in_range) r_rdata <= sa_out;
          r_err   <= !w_in_range || w_mis;
          r_done  <= 1'b1;
          r_cnt   <= '0;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_err   <= 1'b0;
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;
  assign rdata   = r_rdata;
  assign pre_en  = r_pre_en;
  assign wl      = r_wl;
  assign wr_en   = r_wr_en;
  assign wr_data = r_wr_data;
  assign sae     = r_sae;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Vector table + scoreboard bench for sram_access_ctrl (ROWS=8, ADDR_W=4 so out-of-range rows are reachable).
module tb_sram_access_ctrl;
  localparam int P = 2;
  localparam int W = 3;
`ifdef SRAM_WR_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] wdata = '0, cur_sa = '0;
  logic       busy, done, err, pre_en, wr_en, sae;
  logic [7:0] rdata, wl, wr_data, sa_out;

  // Sense data is only valid while sae is high; anything else reads back inverted.
  assign sa_out = sae ? cur_sa : ~cur_sa;

  sram_access_ctrl #(.ROWS(8), .COLS(8), .ADDR_W(4), .PRE_CYC(P), .WL_CYC(W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .pre_en(pre_en), .wl(wl),
    .wr_en(wr_en), .wr_data(wr_data), .sae(sae), .sa_out(sa_out));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic we; logic [3:0] addr; logic [7:0] wdata, sa;
    logic err_d, err_v; logic [7:0] rd_d, rd_v;
  } vec_t;
  typedef struct {
    logic err; logic [7:0] rdata, wdata, wlor;
    int lat, npre, nwl, nwr, nsae;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0, n_done = 0, last_done = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk_exp(input logic iwe, input logic [3:0] iaddr,
                                  input logic [7:0] iwd, input logic ierr, input logic [7:0] ird);
    exp_t e;
    logic inr, wv;
    inr = (iaddr < 4'd8);
    wv  = iwe && VERIFY;
    e.err   = ierr;
    e.rdata = ird;
    e.wdata = iwd;
    e.wlor  = inr ? (8'd1 << iaddr[2:0]) : 8'd0;
    e.npre  = wv ? 2*P : P;
    e.nwl   = inr ? (wv ? 2*W : W) : 0;
    e.nwr   = (inr && iwe) ? W : 0;
    e.nsae  = (inr && (!iwe || VERIFY)) ? 1 : 0;
    e.lat   = iwe ? (VERIFY ? 2 + 2*P + 2*W : 1 + P + W) : 2 + P + W;
    return e;
  endfunction

  // Monitor: accumulate strobe activity per access, check invariants, score at done.
  bit         m_seen = 0;
  int         m_first = 0, m_pre = 0, m_wl = 0, m_wr = 0, m_sae = 0, m_wdbad = 0;
  logic [7:0] m_wlor = '0;
  always @(negedge clk) begin
    if (rst) begin
      m_seen = 0; m_pre = 0; m_wl = 0; m_wr = 0; m_sae = 0; m_wdbad = 0; m_wlor = '0;
    end else begin
      chk("invariant", {pre_en && (|wl || sae), wr_en && !(|wl), $countones(wl) > 1}, 0);
      if (pre_en && !m_seen) begin m_seen = 1; m_first = cyc; end
      if (pre_en) m_pre++;
      if (|wl) m_wl++;
      if (wr_en) m_wr++;
      if (sae) m_sae++;
      m_wlor |= wl;
      if (wr_en && exp_q.size() > 0 && wr_data !== exp_q[0].wdata) m_wdbad++;
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("err",      err, e.err);
          chk("rdata",    rdata, e.rdata);
          chk("latency",  cyc - m_first + 1, e.lat);
          chk("pre_cyc",  m_pre, e.npre);
          chk("wl_cyc",   m_wl, e.nwl);
          chk("wl_row",   m_wlor, e.wlor);
          chk("wr_cyc",   m_wr, e.nwr);
          chk("sae_cyc",  m_sae, e.nsae);
          chk("wr_data",  m_wdbad, 0);
          chk("busy_done", busy, 1);
        end
        n_done++; last_done = cyc;
        m_seen = 0; m_pre = 0; m_wl = 0; m_wr = 0; m_sae = 0; m_wdbad = 0; m_wlor = '0;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (n_done < target && t < 60) begin tick(); t++; end
    chk("done_timeout", n_done >= target, 1);
  endtask

  task automatic do_access(input vec_t v);
    int base;
    tick();
    chk("idle_before_req", busy, 0);
    base = n_done;
    cur_sa = v.sa; req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
    exp_q.push_back(mk_exp(v.we, v.addr, v.wdata, VERIFY ? v.err_v : v.err_d,
                           VERIFY ? v.rd_v : v.rd_d));
    @(posedge clk); #1 req = 1'b0;
    tick();
    chk("accept_busy_pre", {busy, pre_en}, 2'b11);
    wait_done(base + 1);
    tick();
  endtask

  vec_t vt[9];

  initial begin
    int base, d, t;
    logic bsy;
    //         we    addr   wdata  sa     err_d err_v rd_d   rd_v
    vt[0] = '{1'b1, 4'd3,  8'hA5, 8'hA5, 1'b0, 1'b0, 8'h00, 8'hA5};
    vt[1] = '{1'b0, 4'd3,  8'h00, 8'hA5, 1'b0, 1'b0, 8'hA5, 8'hA5};
    vt[2] = '{1'b1, 4'd9,  8'h5A, 8'h11, 1'b1, 1'b1, 8'hA5, 8'hA5};
    vt[3] = '{1'b0, 4'd12, 8'h00, 8'h77, 1'b1, 1'b1, 8'hA5, 8'hA5};
    vt[4] = '{1'b0, 4'd0,  8'h00, 8'h3C, 1'b0, 1'b0, 8'h3C, 8'h3C};
    vt[5] = '{1'b0, 4'd7,  8'h00, 8'hC3, 1'b0, 1'b0, 8'hC3, 8'hC3};
    vt[6] = '{1'b1, 4'd7,  8'h3C, 8'h3D, 1'b0, 1'b1, 8'hC3, 8'h3D};
    vt[7] = '{1'b1, 4'd7,  8'h3C, 8'h3C, 1'b0, 1'b0, 8'hC3, 8'h3C};
    vt[8] = '{1'b1, 4'd8,  8'hFF, 8'h00, 1'b1, 1'b1, 8'hC3, 8'h3C};

    tick(); tick();
    chk("reset_state", {busy, done, err, pre_en, wr_en, sae, wl, wr_data, rdata}, 0);
    rst = 1'b0;
    tick();

    // Reset in the middle of a write's ACCESS phase.
    cur_sa = 8'h00; req = 1'b1; we = 1'b1; addr = 4'd2; wdata = 8'h81;
    @(posedge clk); #1 req = 1'b0;
    t = 0;
    while (!wl[2] && t < 20) begin tick(); t++; end
    chk("mid_access", {wl[2], wr_en}, 2'b11);
    rst = 1'b1;
    #1 chk("rst_async", {pre_en, wl, wr_en, sae, busy, done}, 0);
    tick(); tick();
    rst = 1'b0;
    base = n_done; bsy = 1'b0;
    repeat (12) begin tick(); bsy |= busy; end
    chk("rst_no_done", n_done - base, 0);
    chk("rst_idle", bsy, 0);

    foreach (vt[i]) do_access(vt[i]);

    // req held high through a read: exactly two back-to-back accesses.
    tick();
    base = n_done;
    cur_sa = 8'h5A; req = 1'b1; we = 1'b0; addr = 4'd1;
    exp_q.push_back(mk_exp(1'b0, 4'd1, 8'h00, 1'b0, 8'h5A));
    exp_q.push_back(mk_exp(1'b0, 4'd1, 8'h00, 1'b0, 8'h5A));
    wait_done(base + 1);
    d = last_done;
    t = 0;
    while (!pre_en && t < 6) begin tick(); t++; end
    chk("reaccept_pre", cyc, d + 2);
    req = 1'b0;
    wait_done(base + 2);
    bsy = 1'b0;
    repeat (10) begin tick(); bsy |= busy; end
    chk("two_accesses", n_done - base, 2);
    chk("no_third", bsy, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
